// File: rtl/aibcr3_dll_pkg.sv
// Shared types and constants for the DLL lock-detect loop: FSM states, settle counter width, PD directions.
package aibcr3_dll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    STEP,
    LOCKED_SETTLE,
    LOCKED_STEP
  } dll_state_e;

  localparam int   SETTLE_W = 8;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DN   = 1'b0;

endpackage

// File: rtl/aibcr3_dll_code_ctr.sv
// Saturating up/down delay-code counter; code/sat update on the edge after i_load/i_step, no backpressure.
// o_blk flags combinationally that a step in the current i_dir would be blocked at an end stop.
module aibcr3_dll_code_ctr #(
  parameter int                CODE_W    = 8,
  parameter logic [CODE_W-1:0] CODE_INIT = 8'h80
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_dir,
  output logic [CODE_W-1:0] o_code,
  output logic              o_sat,
  output logic              o_blk
);
  import aibcr3_dll_pkg::*;

  logic [CODE_W-1:0] r_code;
  logic              r_sat;

  assign o_blk  = (i_dir == DIR_UP) ? (&r_code) : (~|r_code);
  assign o_code = r_code;
  assign o_sat  = r_sat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_code <= CODE_INIT;
      r_sat  <= 1'b0;
    end else if (i_load) begin
      r_code <= CODE_INIT;
      r_sat  <= 1'b0;
    end else if (i_step) begin
      if (o_blk) begin
        r_sat <= 1'b1;
      end else begin
        r_sat  <= 1'b0;
        r_code <= (i_dir == DIR_UP) ? r_code + CODE_W'(1) : r_code - CODE_W'(1);
      end
    end
  end

endmodule

// File: rtl/aibcr3_dll_lock_det.sv
// DLL code tracking loop with dither-based lock detect; outputs registered, lock 1 cycle after the locking STEP.
// Optional AIBCR3_DLL_LOCK_FORCE_EN adds lock_force to pin dll_lock high and freeze the code.
module aibcr3_dll_lock_det #(
  parameter int                CODE_W     = 8,
  parameter logic [CODE_W-1:0] CODE_INIT  = 8'h80,
  parameter int                SETTLE_CYC = 7,
  parameter int                LOCK_REV   = 4,
  parameter int                RUN_MAX    = 6
) (
  input  logic              clk_dcd,
  input  logic              RSTb,
  input  logic              cal_en,
  input  logic              pd_up,
  input  logic              rb_cont_cal,
`ifdef AIBCR3_DLL_LOCK_FORCE_EN
  input  logic              lock_force,
`endif
  output logic [CODE_W-1:0] dll_code,
  output logic              dll_lock,
  output logic              code_sat,
  output logic              busy
);
  import aibcr3_dll_pkg::*;

  localparam int REV_W = $clog2(LOCK_REV + 1);
  localparam int RUN_W = $clog2(RUN_MAX + 1);

  dll_state_e          r_state, w_state_nxt;
  logic [SETTLE_W-1:0] r_settle_cnt, w_settle_nxt;
  logic [REV_W-1:0]    r_rev_cnt, w_rev_nxt, w_rev_inc;
  logic [RUN_W-1:0]    r_run_cnt, w_run_nxt, w_run_inc;
  logic                r_last_dir, w_dir_nxt;
  logic                r_first, w_first_nxt;
  logic                r_lock, w_lock_nxt;
  logic                r_busy;
  logic                w_load, w_step, w_blk, w_settle_done, w_rev, w_same;
`ifdef AIBCR3_DLL_LOCK_FORCE_EN
  logic                r_forced, w_forced_nxt;
`endif

  assign w_settle_done = (r_settle_cnt == SETTLE_W'(SETTLE_CYC - 1));
  // r_first masks the stale direction so the first step after IDLE is never a reversal
  assign w_rev     = !r_first && (pd_up != r_last_dir);
  assign w_same    = (pd_up == r_last_dir) || w_blk;
  assign w_rev_inc = r_rev_cnt + REV_W'(1);
  assign w_run_inc = r_run_cnt + RUN_W'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle_cnt;
    w_rev_nxt    = r_rev_cnt;
    w_run_nxt    = r_run_cnt;
    w_dir_nxt    = r_last_dir;
    w_first_nxt  = r_first;
    w_lock_nxt   = r_lock;
    w_load       = 1'b0;
    w_step       = 1'b0;
`ifdef AIBCR3_DLL_LOCK_FORCE_EN
    w_forced_nxt = r_forced;
`endif
    if (!cal_en) begin
      w_state_nxt  = IDLE;
      w_settle_nxt = '0;
      w_rev_nxt    = '0;
      w_run_nxt    = '0;
      w_dir_nxt    = DIR_DN;
      w_first_nxt  = 1'b1;
      w_lock_nxt   = 1'b0;
      w_load       = 1'b1;
`ifdef AIBCR3_DLL_LOCK_FORCE_EN
      w_forced_nxt = 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt  = SETTLE;
          w_settle_nxt = '0;
          w_load       = 1'b1;
        end
        SETTLE, LOCKED_SETTLE: begin
          if (w_settle_done) begin
            w_settle_nxt = '0;
            if (r_state == SETTLE)  w_state_nxt = STEP;
            else if (rb_cont_cal)   w_state_nxt = LOCKED_STEP;
          end else begin
            w_settle_nxt = r_settle_cnt + SETTLE_W'(1);
          end
        end
        STEP: begin
          w_step      = 1'b1;
          w_dir_nxt   = pd_up;
          w_first_nxt = 1'b0;
          w_state_nxt = SETTLE;
          if (!w_rev) begin
            w_rev_nxt = '0;
          end else if (w_rev_inc == REV_W'(LOCK_REV)) begin
            w_rev_nxt   = '0;
            w_run_nxt   = '0;
            w_lock_nxt  = 1'b1;
            w_state_nxt = LOCKED_SETTLE;
          end else begin
            w_rev_nxt = w_rev_inc;
          end
        end
        LOCKED_STEP: begin
          w_step      = 1'b1;
          w_dir_nxt   = pd_up;
          w_state_nxt = LOCKED_SETTLE;
          if (!w_same) begin
            w_run_nxt = '0;
          end else if (w_run_inc == RUN_W'(RUN_MAX)) begin
            // sustained drift: drop lock but keep the code as the starting point
            w_run_nxt   = '0;
            w_rev_nxt   = '0;
            w_lock_nxt  = 1'b0;
            w_state_nxt = SETTLE;
          end else begin
            w_run_nxt = w_run_inc;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
`ifdef AIBCR3_DLL_LOCK_FORCE_EN
      if (lock_force && (r_state != IDLE)) begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle_cnt;
        w_rev_nxt    = r_rev_cnt;
        w_run_nxt    = r_run_cnt;
        w_dir_nxt    = r_last_dir;
        w_first_nxt  = r_first;
        w_step       = 1'b0;
        w_lock_nxt   = 1'b1;
        w_forced_nxt = 1'b1;
      end else if (r_forced) begin
        w_state_nxt  = SETTLE;
        w_settle_nxt = '0;
        w_rev_nxt    = '0;
        w_run_nxt    = '0;
        w_step       = 1'b0;
        w_lock_nxt   = 1'b0;
        w_forced_nxt = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk_dcd or negedge RSTb) begin
    if (!RSTb) begin
      r_state      <= IDLE;
      r_settle_cnt <= '0;
      r_rev_cnt    <= '0;
      r_run_cnt    <= '0;
      r_last_dir   <= DIR_DN;
      r_first      <= 1'b1;
      r_lock       <= 1'b0;
      r_busy       <= 1'b0;
`ifdef AIBCR3_DLL_LOCK_FORCE_EN
      r_forced     <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_rev_cnt    <= w_rev_nxt;
      r_run_cnt    <= w_run_nxt;
      r_last_dir   <= w_dir_nxt;
      r_first      <= w_first_nxt;
      r_lock       <= w_lock_nxt;
      r_busy       <= (w_state_nxt != IDLE);
`ifdef AIBCR3_DLL_LOCK_FORCE_EN
      r_forced     <= w_forced_nxt;
`endif
    end
  end

  aibcr3_dll_code_ctr #(
    .CODE_W    (CODE_W),
    .CODE_INIT (CODE_INIT)
  ) u_code_ctr (
    .i_clk   (clk_dcd),
    .i_rst_n (RSTb),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_dir   (pd_up),
    .o_code  (dll_code),
    .o_sat   (code_sat),
    .o_blk   (w_blk)
  );

  assign dll_lock = r_lock;
  assign busy     = r_busy;

endmodule

// File: doc/aibcr3_dll_lock_det.md
Name: aibcr3_dll_lock_det

Overview:
- Upstream neighbour of the DLL lock-delay/DCC-done shift chain.
- Runs the DLL delay-code tracking loop from phase-detector decisions and detects lock from dither, i.e. repeated direction reversals.
- Drives dll_lock, which feeds the lock mux and then the lock-delay chain.
- In continuous-calibration mode it keeps tracking after lock and drops lock on sustained one-directional drift.

Parameters:
- CODE_W, 8: width of delay code.
- CODE_INIT, 8'h80: code loaded on reset and whenever cal_en is low.
- SETTLE_CYC, 7: clk_dcd cycles waited after each code step before pd_up is sampled. Legal range 1..255.
- LOCK_REV, 4: consecutive direction reversals required to declare lock.
- RUN_MAX, 6: consecutive same-direction steps while LOCKED that force loss of lock.

Ports:
- clk_dcd  input  1  loop clock.
- RSTb  input  1  asynchronous active-low reset.
- cal_en  input  1  calibration enable. Synchronous to clk_dcd; level-sensitive.
- pd_up  input  1  phase-detector decision: 1 = increase delay, 0 = decrease. Sampled only at decision points.
- rb_cont_cal  input  1  1 = keep tracking after lock; 0 = freeze code at lock.
- dll_code  output  CODE_W  delay-line control code.
- dll_lock  output  1  lock indication to the lock mux.
- code_sat  output  1  last step was blocked at 0 or at max code.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (RSTb=0, asynchronous):
  - state=IDLE, dll_code=CODE_INIT, dll_lock=0, code_sat=0, busy=0.
  - All counters are 0; last-direction register is 0.
- States: IDLE, SETTLE, STEP, LOCKED_SETTLE, LOCKED_STEP.
- IDLE:
  - dll_code is held at CODE_INIT; dll_lock=0.
  - cal_en=1 -> SETTLE on the next edge, with settle counter cleared.
- SETTLE: the settle counter increments each cycle. When it reaches SETTLE_CYC-1 -> STEP.
- STEP (one cycle):
  - Sample pd_up and compute the new code.
  - pd_up=1: code+1, saturating at 2^CODE_W-1.
  - pd_up=0: code-1, saturating at 0.
  - code_sat=1 if the step was blocked by saturation, else 0.
  - rev=1 if pd_up differs from the last direction. The first step after IDLE never counts as a reversal.
  - rev=1: reversal count +1. rev=0: reversal count cleared to 0.
  - If the reversal count reaches LOCK_REV on this step: dll_lock=1 on the next edge and go to LOCKED_SETTLE if rb_cont_cal=1, else LOCKED_SETTLE with stepping frozen.
  - Otherwise -> SETTLE.
  - The last direction is updated to pd_up.
- Lock latency: dll_lock rises exactly 1 cycle after the STEP cycle that completes the LOCK_REV-th consecutive reversal.
- LOCKED_SETTLE / LOCKED_STEP:
  - rb_cont_cal=0: the code is frozen, dll_lock stays 1, and pd_up is ignored.
  - rb_cont_cal=1: the same settle/step as above.
    - The run count increments on a same-direction step and clears on a reversal.
    - A step blocked by saturation counts as same-direction.
  - When the run count reaches RUN_MAX: dll_lock=0 on the next edge, all counters cleared, go to SETTLE. dll_code is kept; it is not reloaded.
- cal_en falling in any state: on the next edge go to IDLE, dll_code=CODE_INIT, dll_lock=0, counters cleared. This takes priority over a step in the same cycle.
- rb_cont_cal toggling while locked takes effect at the next settle completion and never drops lock by itself.
- Reset mid-operation: immediate return to the reset values. No partial step is committed.
- All outputs are registered; there are no combinational paths from the inputs.

Optional Feature:
- Macro: AIBCR3_DLL_LOCK_FORCE_EN.
- With the macro defined:
  - Adds input lock_force (1 bit).
  - lock_force=1 drives dll_lock=1 on the next edge from any state except IDLE, and freezes dll_code.
  - Releasing lock_force returns to SETTLE with dll_lock=0 and counters cleared.
- Without the macro: no port and no logic.

Decomposition:
- Package aibcr3_dll_pkg holds:
  - the state enum (IDLE, SETTLE, STEP, LOCKED_SETTLE, LOCKED_STEP);
  - the localparam for the settle counter width (8);
  - the direction constants DIR_UP=1, DIR_DN=0.
- One natural sub-module: aibcr3_dll_code_ctr, a saturating up/down code counter with a load-init input and a sat flag output.

Test Plan:
- Reset check: assert RSTb=0 mid-SETTLE -> dll_code=8'h80, dll_lock=0, busy=0 immediately. With cal_en=1 after release, the first STEP occurs 8 cycles later.
- Lock acquisition: cal_en=1, pd_up sequence 1,1,1,0,1,0,1 at successive STEPs.
  - Code goes 81,82,83,82,83,82,83.
  - dll_lock=1 one cycle after the 7th STEP, which is the 4th reversal.
- Reversal reset: pd_up sequence 1,0,1,1,0,1,0,1 -> no lock until the 8th STEP, because the reversal count was cleared at step 4.
- Saturation: CODE_INIT=8'hFE, pd_up held 1.
  - Code goes FF, FF.
  - code_sat=1 from the 2nd STEP; no lock.
- Loss of lock: reach lock with rb_cont_cal=1, then pd_up=1 for 6 steps -> dll_lock falls after the 6th step, and the code has advanced by 6.
- Freeze and abort: lock with rb_cont_cal=0.
  - Toggle pd_up for 50 cycles -> code unchanged.
  - Drop cal_en -> next edge: IDLE, dll_code=8'h80, dll_lock=0.
